// File: rtl/imul_shared_arbiter.sv
// Round-robin sharing of one variable-latency multiplier between two requesters.
// Requests and responses pass straight through; only one operation is in flight at a time.
module imul_shared_arbiter #(
  parameter int p_msg_nbits = 67,
  parameter int p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  logic [p_msg_nbits-1:0] req0_msg,
  input  logic                   req1_val,
  output logic                   req1_rdy,
  input  logic [p_msg_nbits-1:0] req1_msg,
  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output logic [31:0]            resp0_msg,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,
  output logic [31:0]            resp1_msg,
  output logic                   mul_in_val,
  input  logic                   mul_in_rdy,
  output logic [p_msg_nbits-1:0] mul_in_msg,
  input  logic                   mul_out_val,
  output logic                   mul_out_rdy,
  input  logic [31:0]            mul_out_msg,
  output logic [p_cnt_nbits-1:0] done_cnt0,
  output logic [p_cnt_nbits-1:0] done_cnt1
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   prio, prio_nxt;
  logic   grant_any, grant;
  logic   inc0, inc1;

  // prio only breaks ties; a lone requester always wins
  assign grant_any = req0_val | req1_val;
  assign grant     = (req0_val & req1_val) ? prio : req1_val;

  assign resp0_msg = mul_out_msg;
  assign resp1_msg = mul_out_msg;

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    prio_nxt    = prio;
    inc0        = 1'b0;
    inc1        = 1'b0;
    req0_rdy    = 1'b0;
    req1_rdy    = 1'b0;
    mul_in_val  = 1'b0;
    mul_in_msg  = req0_msg;
    resp0_val   = 1'b0;
    resp1_val   = 1'b0;
    mul_out_rdy = 1'b0;
    case (state)
      IDLE: begin
        mul_in_val = grant_any;
        if (grant) mul_in_msg = req1_msg;
        req0_rdy = grant_any & ~grant & mul_in_rdy;
        req1_rdy = grant_any &  grant & mul_in_rdy;
        if (mul_in_val && mul_in_rdy) begin
          state_nxt = WAIT;
          owner_nxt = grant;
        end
      end
      WAIT: begin
        resp0_val   = ~owner & mul_out_val;
        resp1_val   =  owner & mul_out_val;
        mul_out_rdy = owner ? resp1_rdy : resp0_rdy;
        if (mul_out_val && mul_out_rdy) begin
          state_nxt = IDLE;
          prio_nxt  = ~owner;
          inc0      = ~owner;
          inc1      =  owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      prio      <= 1'b0;
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      prio  <= prio_nxt;
      // counters stick at all-ones instead of wrapping
      if (inc0 && (done_cnt0 != '1)) done_cnt0 <= done_cnt0 + p_cnt_nbits'(1);
      if (inc1 && (done_cnt1 != '1)) done_cnt1 <= done_cnt1 + p_cnt_nbits'(1);
    end
  end

endmodule

// File: doc/imul_shared_arbiter.md
Name: imul_shared_arbiter

Overview:
- Shares one variable-latency integer multiplier (val/rdy request in, 32-bit result out) between two requesters.
- Arbitrates round-robin among requesters and forwards the winning request to the multiplier.
- Tracks which requester owns the single in-flight operation and steers the result back to that requester only.
- Keeps saturating per-requester completion counters for performance monitoring.

Parameters:
- p_msg_nbits, 67, request message width (func + a + b, the packed multiply request format).
- p_cnt_nbits, 16, width of each completion counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req0_val / req1_val  in  1  request valid from requester 0 / 1.
- req0_rdy / req1_rdy  out  1  request ready to requester 0 / 1.
- req0_msg / req1_msg  in  p_msg_nbits  request payloads.
- resp0_val / resp1_val  out  1  response valid to requester 0 / 1.
- resp0_rdy / resp1_rdy  in  1  response ready from requester 0 / 1.
- resp0_msg / resp1_msg  out  32  response payloads; both driven from mul_out_msg.
- mul_in_val  out  1  request valid to the multiplier.
- mul_in_rdy  in  1  multiplier ready to accept a request.
- mul_in_msg  out  p_msg_nbits  request payload to the multiplier.
- mul_out_val  in  1  multiplier result valid.
- mul_out_rdy  out  1  result ready to the multiplier.
- mul_out_msg  in  32  multiplier result.
- done_cnt0 / done_cnt1  out  p_cnt_nbits  completed transactions per requester.

Behaviour:
- States:
  - IDLE: no operation outstanding.
  - WAIT: one operation outstanding.
- Registers:
  - state
  - owner (1 bit)
  - prio (1 bit): the requester favoured on a tie
  - done_cnt0, done_cnt1
- Reset (reset==0, asynchronous): state=IDLE, owner=0, prio=0, done_cnt0=done_cnt1=0.
  - All val/rdy outputs are 0 during reset and in the first cycle after release, because they decode from IDLE with no requests valid.
  - Reset mid-operation abandons the in-flight operation. The multiplier is reset by the same signal.
- Grant, in IDLE only, combinational:
  - If exactly one reqN_val=1, grant=N.
  - If both are valid, grant=prio.
  - If neither is valid, there is no grant.
- IDLE outputs:
  - mul_in_val = reqgrant_val.
  - mul_in_msg = reqgrant_msg; when no grant, mul_in_msg = req0_msg (don't care).
  - reqgrant_rdy = mul_in_rdy; the non-granted req_rdy = 0.
  - resp*_val = 0; mul_out_rdy = 0.
- IDLE transition: on mul_in_val && mul_in_rdy, set owner=grant and go to WAIT next cycle. Otherwise stay in IDLE.
- Request latency: request forwarding is combinational (zero cycles). There is no request buffering.
- WAIT outputs:
  - req0_rdy = req1_rdy = 0; mul_in_val = 0.
  - respowner_val = mul_out_val; the other resp_val = 0.
  - mul_out_rdy = respowner_rdy.
- WAIT transition: on mul_out_val && mul_out_rdy:
  - Go to IDLE.
  - Set prio = ~owner.
  - Increment done_cntowner, saturating at all-ones.
- Response latency: the response path is combinational pass-through.
- At most one operation is outstanding at a time. A new request is never issued in the same cycle as a response handshake; the earliest re-issue is the cycle after return to IDLE.
- Simultaneous events:
  - A requester holding val while the other is served keeps val asserted; after one completion it wins, because of the prio flip.
  - Lowering reqN_val before it is granted is permitted; the arbiter holds no stale state.
- Requester starvation is bounded to one transaction.
- Backpressure: an owner holding respowner_rdy=0 stalls indefinitely in WAIT. The non-owner is never granted during this stall.
- Counters wrap: never. They saturate at 2^p_cnt_nbits-1.

Test Plan:
- Single requester: req0 a=3, b=5, mul_in_rdy=1 → mul_in_val same cycle, state WAIT, resp0_val with 15 when the multiplier returns; resp1_val stays 0; done_cnt0=1.
- Contention: both valid in the same cycle after reset, req0 a=7,b=6 and req1 a=2,b=9 → req0 served first (result 42), then req1 (result 18); grants alternate 0,1,0,1 over 4 back-to-back pairs.
- Backpressure: resp1_rdy=0 for 10 cycles while mul_out_val=1 → mul_out_rdy=0, state WAIT, req0_rdy=0 throughout; completes on the cycle resp1_rdy=1.
- Multiplier stall: mul_in_rdy=0 for 5 cycles with req0_val=1 → req0_rdy=0, state IDLE; the handshake occurs in the first cycle mul_in_rdy=1.
- Async reset mid-op: assert reset in WAIT between clock edges → outputs drop immediately, done counts=0, prio=0; after release req1 alone is granted normally.
- Saturation: p_cnt_nbits=2, 5 req0 transactions → done_cnt0 reads 1,2,3,3,3.
